// File: rtl/i2c_poller_pkg.sv
// Shared types and constants for the I2C register poller.
// Holds the sequencer state encoding and the error codes reported to consumers.
package i2c_poller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        ADDR_W,
        REG_PTR,
        ADDR_R,
        READ,
        DONE,
        BACKOFF
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_NACK  = 2'd1;
    localparam logic [1:0] ERR_START = 2'd2;
    localparam logic [1:0] ERR_ARB   = 2'd3;

    // Arbitration loss outranks a start error, which outranks a bad ack bit.
    function automatic logic [1:0] err_classify(input logic arb_err, input logic st_err);
        if (arb_err) return ERR_ARB;
        if (st_err)  return ERR_START;
        return ERR_NACK;
    endfunction

endpackage

// File: rtl/i2c_poll_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Used both for the auto-poll interval and for the retry back-off.
module i2c_poll_timer #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_in,
    input  logic             RESETn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_in or negedge RESETn) begin
        if (!RESETn) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/i2c_reg_poller.sv
// Register-burst reader sequencing i2c_master: address write, pointer write,
// repeated start, address read and an N-byte read, with retry and auto-poll.
module i2c_reg_poller #(
    parameter logic [6:0]  DEVICE_ADDR    = 7'h6B,
    parameter logic [7:0]  FIRST_REG      = 8'h08,
    parameter int unsigned NUM_REGS       = 1,
    parameter int unsigned POLL_INTERVAL  = 4800000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned BACKOFF_CYCLES = 4800
) (
    input  logic                  clk_in,
    input  logic                  RESETn,
    input  logic                  enable,
    input  logic                  trigger,
    input  logic                  transfer_ready,
    input  logic                  interrupt,
    input  logic                  transaction_complete,
    input  logic                  nack,
    input  logic                  start_err,
    input  logic                  arbitration_err,
    input  logic [7:0]            data_rx,
    output logic                  mode,
    output logic                  transfer_start,
    output logic                  transfer_continue,
    output logic [7:0]            data_tx,
    output logic [8*NUM_REGS-1:0] regs,
    output logic                  regs_valid,
    output logic                  busy,
    output logic                  fail,
    output logic [1:0]            err_code,
    output logic [3:0]            retry_count
);

    import i2c_poller_pkg::*;

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned POLL_W = (POLL_INTERVAL > 0) ? $clog2(POLL_INTERVAL + 1) : 1;
    localparam int unsigned BACK_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    localparam logic [POLL_W-1:0] POLL_LOAD   = POLL_W'(POLL_INTERVAL);
    localparam logic [BACK_W-1:0] BACK_LOAD   = (BACKOFF_CYCLES > 0) ? BACK_W'(BACKOFF_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_REGS - 1);
    localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRIES);

    state_t state, state_nxt;

    logic                  mode_nxt;
    logic                  start_nxt;
    logic                  cont_nxt;
    logic [7:0]            data_tx_nxt;
    logic [8*NUM_REGS-1:0] regs_nxt;
    logic                  regs_valid_nxt;
    logic                  fail_nxt;
    logic [1:0]            err_code_nxt;
    logic [3:0]            retry_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [8*NUM_REGS-1:0] shadow, shadow_nxt;

    logic poll_load, poll_en, poll_expired;
    logic back_load, back_en, back_expired;
    logic got, bus_err, exp_nack, nack_bad, byte_active, err_hit;

    // Poll timer holds "remaining" rather than "elapsed"; reload == elapsed back to 0.
    i2c_poll_timer #(
        .WIDTH       (POLL_W),
        .RESET_VALUE (POLL_LOAD)
    ) u_poll_timer (
        .clk_in     (clk_in),
        .RESETn     (RESETn),
        .load       (poll_load),
        .load_value (POLL_LOAD),
        .en         (poll_en),
        .expired    (poll_expired)
    );

    i2c_poll_timer #(
        .WIDTH       (BACK_W),
        .RESET_VALUE ('0)
    ) u_backoff_timer (
        .clk_in     (clk_in),
        .RESETn     (RESETn),
        .load       (back_load),
        .load_value (BACK_LOAD),
        .en         (back_en),
        .expired    (back_expired)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk_in or negedge RESETn) begin
        if (!RESETn) begin
            state             <= IDLE;
            mode              <= 1'b0;
            transfer_start    <= 1'b0;
            transfer_continue <= 1'b0;
            data_tx           <= '0;
            regs              <= '0;
            regs_valid        <= 1'b0;
            fail              <= 1'b0;
            err_code          <= ERR_NONE;
            retry_count       <= '0;
            idx               <= '0;
            shadow            <= '0;
        end else begin
            state             <= state_nxt;
            mode              <= mode_nxt;
            transfer_start    <= start_nxt;
            transfer_continue <= cont_nxt;
            data_tx           <= data_tx_nxt;
            regs              <= regs_nxt;
            regs_valid        <= regs_valid_nxt;
            fail              <= fail_nxt;
            err_code          <= err_code_nxt;
            retry_count       <= retry_nxt;
            idx               <= idx_nxt;
            shadow            <= shadow_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        mode_nxt       = mode;
        start_nxt      = transfer_start;
        cont_nxt       = transfer_continue;
        data_tx_nxt    = data_tx;
        regs_nxt       = regs;
        regs_valid_nxt = 1'b0;
        fail_nxt       = 1'b0;
        err_code_nxt   = err_code;
        retry_nxt      = retry_count;
        idx_nxt        = idx;
        shadow_nxt     = shadow;

        poll_load = (state != IDLE);
        poll_en   = (state == IDLE) && enable;
        back_load = (state != BACKOFF);
        back_en   = (state == BACKOFF);

        got         = interrupt && transaction_complete;
        bus_err     = interrupt && (start_err || arbitration_err);
        exp_nack    = (state == READ) && (idx == LAST_IDX);
        nack_bad    = got && (nack != exp_nack);
        byte_active = (state == ADDR_W) || (state == REG_PTR) ||
                      (state == ADDR_R) || (state == READ);
        err_hit     = byte_active && (bus_err || nack_bad);

        case (state)
            IDLE: begin
                if (trigger || (enable && (POLL_INTERVAL != 0) && poll_expired)) begin
                    state_nxt = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (transfer_ready) begin
                    start_nxt   = 1'b1;
                    cont_nxt    = 1'b1;
                    mode_nxt    = 1'b0;
                    data_tx_nxt = {DEVICE_ADDR, 1'b0};
                    state_nxt   = ADDR_W;
                end
            end
            ADDR_W: begin
                if (got && !nack) begin
                    start_nxt   = 1'b0;
                    cont_nxt    = 1'b0;
                    mode_nxt    = 1'b0;
                    data_tx_nxt = FIRST_REG;
                    state_nxt   = REG_PTR;
                end
            end
            REG_PTR: begin
                if (got && !nack) begin
                    start_nxt   = 1'b1;
                    cont_nxt    = 1'b0;
                    mode_nxt    = 1'b0;
                    data_tx_nxt = {DEVICE_ADDR, 1'b1};
                    state_nxt   = ADDR_R;
                end
            end
            ADDR_R: begin
                if (got && !nack) begin
                    start_nxt = 1'b0;
                    mode_nxt  = 1'b1;
                    cont_nxt  = (NUM_REGS > 1);
                    idx_nxt   = '0;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (got && !nack_bad) begin
                    shadow_nxt[{idx, 3'b000} +: 8] = data_rx;
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt  = idx + 1'b1;
                        cont_nxt = ((32'(idx) + 32'd2) < NUM_REGS);
                    end
                end
            end
            DONE: begin
                regs_nxt       = shadow;
                regs_valid_nxt = 1'b1;
                retry_nxt      = '0;
                err_code_nxt   = ERR_NONE;
                state_nxt      = IDLE;
            end
            BACKOFF: begin
                if (back_expired) begin
                    state_nxt = WAIT_READY;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Errors override whatever the per-state success path decided above.
        if (err_hit) begin
            err_code_nxt = err_classify(arbitration_err && interrupt, start_err && interrupt);
            start_nxt    = 1'b0;
            cont_nxt     = 1'b0;
            if (retry_count < RETRY_LIMIT) begin
                retry_nxt = retry_count + 1'b1;
                state_nxt = BACKOFF;
            end else begin
                fail_nxt  = 1'b1;
                retry_nxt = '0;
                state_nxt = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_poller.sv
// Bench for i2c_reg_poller: a behavioural i2c_master/target model with random
// data, latency and fault injection, checked by immediate assertions.
module tb_i2c_reg_poller;

    localparam logic [6:0] DEV   = 7'h6B;
    localparam logic [7:0] FIRST = 8'h08;
    localparam int N    = 4;
    localparam int P    = 1000;
    localparam int MAXR = 3;
    localparam int B    = 20;

    logic        clk_in, RESETn, enable, trigger;
    logic        transfer_ready, interrupt, transaction_complete, nack, start_err, arbitration_err;
    logic [7:0]  data_rx;
    logic        mode, transfer_start, transfer_continue;
    logic [7:0]  data_tx;
    logic [8*N-1:0] regs;
    logic        regs_valid, busy, fail;
    logic [1:0]  err_code;
    logic [3:0]  retry_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [256];
    int          inj_n, inj_type, inj_phase, inj_att;
    logic        m_active;
    int          m_phase, m_wait;
    logic [7:0]  m_ptr;
    logic [31:0] model_regs;

    i2c_reg_poller #(
        .DEVICE_ADDR    (DEV),
        .FIRST_REG      (FIRST),
        .NUM_REGS       (N),
        .POLL_INTERVAL  (P),
        .MAX_RETRIES    (MAXR),
        .BACKOFF_CYCLES (B)
    ) dut (
        .clk_in               (clk_in),
        .RESETn               (RESETn),
        .enable               (enable),
        .trigger              (trigger),
        .transfer_ready       (transfer_ready),
        .interrupt            (interrupt),
        .transaction_complete (transaction_complete),
        .nack                 (nack),
        .start_err            (start_err),
        .arbitration_err      (arbitration_err),
        .data_rx              (data_rx),
        .mode                 (mode),
        .transfer_start       (transfer_start),
        .transfer_continue    (transfer_continue),
        .data_tx              (data_tx),
        .regs                 (regs),
        .regs_valid           (regs_valid),
        .busy                 (busy),
        .fail                 (fail),
        .err_code             (err_code),
        .retry_count          (retry_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Master + target model: one byte phase per command, random latency,
    // occasional interrupt without completion, and scripted error injection.
    initial begin
        int  k;
        logic inject;
        transfer_ready = 1'b1;
        interrupt = 1'b0; transaction_complete = 1'b0; nack = 1'b0;
        start_err = 1'b0; arbitration_err = 1'b0; data_rx = '0;
        m_active = 1'b0; m_phase = 0; m_wait = 0; m_ptr = '0;
        forever begin
            @(negedge clk_in);
            interrupt = 1'b0; transaction_complete = 1'b0; nack = 1'b0;
            start_err = 1'b0; arbitration_err = 1'b0;
            if (!RESETn) begin
                m_active = 1'b0;
                transfer_ready = 1'b1;
            end else if (!m_active) begin
                if (transfer_start && transfer_ready) begin
                    m_active = 1'b1;
                    transfer_ready = 1'b0;
                    m_phase = 0;
                    m_wait = $urandom_range(2, 5);
                end
            end else if (m_wait > 1) begin
                m_wait--;
                if (m_wait == 1 && $urandom_range(0, 3) == 0) interrupt = 1'b1;
            end else begin
                inject = (inj_att < inj_n) && (m_phase == inj_phase);
                if (m_phase <= 2) begin
                    chk("write_mode", mode, 0);
                    if (m_phase == 0) begin
                        chk("addr_w_byte", data_tx, {DEV, 1'b0});
                        chk("addr_w_start", transfer_start, 1);
                    end else if (m_phase == 1) begin
                        chk("reg_ptr_byte", data_tx, FIRST);
                        chk("reg_ptr_start", transfer_start, 0);
                        m_ptr = data_tx;
                    end else begin
                        chk("addr_r_byte", data_tx, {DEV, 1'b1});
                        chk("addr_r_start", transfer_start, 1);
                    end
                    nack = 1'b0;
                end else begin
                    k = m_phase - 3;
                    chk("read_mode", mode, 1);
                    chk("read_start", transfer_start, 0);
                    chk("read_continue", transfer_continue, (k < N - 1));
                    data_rx = mem[8'(int'(m_ptr) + k)];
                    nack = !transfer_continue;
                end
                if (inject) begin
                    if (inj_type == 1) begin
                        nack = !nack;
                    end else if (inj_type == 2) begin
                        start_err = 1'b1;
                        nack = 1'($urandom_range(0, 1));
                    end else begin
                        arbitration_err = 1'b1;
                        start_err = 1'($urandom_range(0, 1));
                        nack = 1'($urandom_range(0, 1));
                    end
                end
                interrupt = 1'b1;
                transaction_complete = 1'b1;
                if (inject || m_phase == 2 + N) begin
                    m_active = 1'b0;
                    transfer_ready = 1'b1;
                    if (inject) inj_att++;
                end else begin
                    m_phase++;
                    m_wait = $urandom_range(2, 5);
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk(tag, {mode, transfer_start, transfer_continue, data_tx, regs_valid,
                  busy, fail, err_code, retry_count}, 0);
        chk({tag, "_regs"}, regs, 0);
    endtask

    // Waits for regs_valid or fail; measures every retry back-off on the way.
    task automatic wait_burst_end(output logic got_valid, output logic got_fail);
        logic [3:0] last_rc;
        logic       in_bo;
        int         gap;
        got_valid = 1'b0; got_fail = 1'b0;
        last_rc = retry_count; in_bo = 1'b0; gap = 0;
        for (int cyc = 0; cyc < 20000 && !got_valid && !got_fail; cyc++) begin
            @(negedge clk_in);
            if (retry_count != last_rc && retry_count != 0) begin
                in_bo = 1'b1;
                gap = 0;
            end
            last_rc = retry_count;
            if (in_bo) begin
                if (transfer_start) begin
                    chk("backoff_gap", gap, B + 1);
                    in_bo = 1'b0;
                end else begin
                    gap++;
                end
            end
            if (regs_valid) begin
                got_valid = 1'b1;
                chk("busy_low_at_valid", busy, 0);
            end
            if (fail) got_fail = 1'b1;
        end
        chk("burst_end_seen", got_valid | got_fail, 1);
    endtask

    task automatic do_burst(input int n, input int typ, input int ph, input logic new_data);
        logic [31:0] exp;
        logic        v, f;
        if (new_data) begin
            for (int k = 0; k < N; k++) mem[8'(int'(FIRST) + k)] = 8'($urandom);
        end
        exp = '0;
        for (int k = 0; k < N; k++) exp[8*k +: 8] = mem[8'(int'(FIRST) + k)];
        inj_n = n; inj_type = typ; inj_phase = ph; inj_att = 0;
        trigger = 1'b1;
        @(negedge clk_in);
        trigger = 1'b0;
        chk("busy_after_trigger", busy, 1);
        trigger = 1'b1;
        @(negedge clk_in);
        trigger = 1'b0;
        wait_burst_end(v, f);
        if (n <= MAXR) begin
            chk("burst_valid", v, 1);
            chk("burst_no_fail", f, 0);
            chk("burst_regs", regs, exp);
            chk("burst_err_cleared", err_code, 0);
            chk("burst_retry_cleared", retry_count, 0);
            model_regs = exp;
        end else begin
            chk("exhaust_fail", f, 1);
            chk("exhaust_no_valid", v, 0);
            chk("exhaust_err_code", err_code, typ);
            chk("exhaust_regs_kept", regs, model_regs);
            chk("exhaust_retry_cleared", retry_count, 0);
        end
        @(negedge clk_in);
        chk("pulse_one_cycle", {regs_valid, fail}, 0);
        if (n > MAXR) chk("err_code_holds", err_code, typ);
        repeat (5) @(negedge clk_in);
        chk("busy_trigger_not_queued", busy, 0);
    endtask

    initial begin
        logic v, f;
        int   gap;
        logic seen;
        RESETn = 1'b0; enable = 1'b0; trigger = 1'b0;
        inj_n = 0; inj_type = 1; inj_phase = 0; inj_att = 0;
        model_regs = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk_in);
        chk_reset_state("reset");
        RESETn = 1'b1;
        @(negedge clk_in);
        chk_reset_state("after_release");

        mem[8'h08] = 8'h11; mem[8'h09] = 8'h22; mem[8'h0A] = 8'h33; mem[8'h0B] = 8'h44;
        do_burst(0, 1, 0, 1'b0);
        chk("burst_literal", regs, 32'h44332211);

        do_burst(2, 1, 0, 1'b1);
        do_burst(15, 3, $urandom_range(0, 2 + N), 1'b1);

        for (int r = 0; r < 12; r++) begin
            do_burst($urandom_range(0, MAXR + 1), $urandom_range(1, 3),
                     $urandom_range(0, 2 + N), 1'b1);
        end

        inj_n = 0; inj_att = 0;
        enable = 1'b1;
        for (int c = 0; c < 3000 && !busy; c++) @(negedge clk_in);
        chk("poll_first_start", busy, 1);
        for (int i = 0; i < 2; i++) begin
            trigger = 1'b1;
            @(negedge clk_in);
            trigger = 1'b0;
            wait_burst_end(v, f);
            chk("poll_valid", v, 1);
            chk("poll_regs", regs, model_regs);
            gap = 1;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk_in);
                if (busy) break;
                gap++;
            end
            chk("poll_idle_gap", gap, P + 1);
        end
        enable = 1'b0;
        wait_burst_end(v, f);
        chk("poll_last_valid", v, 1);
        seen = 1'b0;
        repeat (2500) begin
            @(negedge clk_in);
            if (busy) seen = 1'b1;
        end
        chk("no_poll_when_disabled", seen, 0);

        inj_n = 0; inj_att = 0;
        trigger = 1'b1;
        @(negedge clk_in);
        trigger = 1'b0;
        for (int c = 0; c < 500 && !(m_active && m_phase == 4); c++) @(negedge clk_in);
        chk("reached_read", m_phase, 4);
        #3 RESETn = 1'b0;
        #1 chk_reset_state("async_reset_mid_read");
        model_regs = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        RESETn = 1'b1;
        @(negedge clk_in);
        do_burst(0, 1, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
